lfsr_prng: RTL and testbench

//   Parametrised Fibonacci LFSR pseudo-random generator; successor to the fixed 4-bit generator.

---
 rtl/lfsr_pkg.sv | 33 +++
 rtl/lfsr_prng.sv | 67 ++++++
 tb/tb_lfsr_prng.sv | 139 +++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: maximal-length tap table and single-step helper shared by the LFSR generators
package lfsr_pkg;

    localparam int MIN_W = 3;
    localparam int MAX_W = 16;

    // Feedback masks, 0-indexed bit positions, for primitive polynomials of degree 3..16
    function automatic logic [15:0] lfsr_taps(input int w);
        case (w)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    // One Fibonacci step: shift toward MSB, parity of tapped bits enters bit 0, result trimmed to w bits
    function automatic logic [15:0] lfsr_step(input logic [15:0] state, input logic [15:0] taps, input int w);
        return {state[14:0], ^(state & taps)} & ((16'(1) << w) - 16'(1));
    endfunction

endpackage

// File: rtl/lfsr_prng.sv
// lfsr_prng: parametrised Fibonacci LFSR with multi-step advance, seed load, lockup guard and wrap pulse
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int STEPS      = 1,
    parameter int RESET_SEED = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] data_out,
    output logic             wrap
);

    localparam logic [15:0]      TAPS  = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] SEED0 = WIDTH'(RESET_SEED);

    if (WIDTH < MIN_W || WIDTH > MAX_W) begin : g_bad_width
        $error("lfsr_prng: WIDTH %0d outside %0d..%0d", WIDTH, MIN_W, MAX_W);
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
        $error("lfsr_prng: STEPS %0d outside 1..WIDTH", STEPS);
    end
    if (RESET_SEED <= 0 || RESET_SEED >= (1 << WIDTH)) begin : g_bad_seed
        $error("lfsr_prng: RESET_SEED %0d not a legal non-zero state", RESET_SEED);
    end

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_origin;
    logic             r_wrap;
    logic [15:0]      w_chain;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_seed;

    // Chain STEPS single steps within the cycle; an all-zero result (upset only) falls back to the reset seed
    always_comb begin
        w_chain = 16'(r_state);
        for (int i = 0; i < STEPS; i++) w_chain = lfsr_step(w_chain, TAPS, WIDTH);
        w_next = (w_chain[WIDTH-1:0] == '0) ? SEED0 : w_chain[WIDTH-1:0];
        w_seed = (seed == '0) ? SEED0 : seed;
    end

    // State, origin and wrap update with priority rst > load > en > hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= SEED0;
            r_origin <= SEED0;
            r_wrap   <= 1'b0;
        end else if (load) begin
            r_state  <= w_seed;
            r_origin <= w_seed;
            r_wrap   <= 1'b0;
        end else if (en) begin
            r_state  <= w_next;
            r_wrap   <= (w_next == r_origin);
        end else begin
            r_wrap   <= 1'b0;
        end
    end

    assign data_out = r_state;
    assign wrap     = r_wrap;

endmodule

// File: tb/tb_lfsr_prng.sv
// tb_lfsr_prng: directed checks of the LFSR generator at widths 4, 8 and 16
module tb_lfsr_prng;

    logic        clk = 1'b0;
    logic        rst, load;
    logic        en_a, en_b, en_8, en_16;
    logic [3:0]  seed;
    logic [3:0]  dout_a, dout_b;
    logic [7:0]  dout_8;
    logic [15:0] dout_16;
    logic        wrap_a, wrap_b, wrap_8, wrap_16;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    lfsr_prng #(.WIDTH(4), .STEPS(1), .RESET_SEED(1)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .load(load), .seed(seed), .data_out(dout_a), .wrap(wrap_a));
    lfsr_prng #(.WIDTH(4), .STEPS(2), .RESET_SEED(1)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .load(1'b0), .seed(4'h0), .data_out(dout_b), .wrap(wrap_b));
    lfsr_prng #(.WIDTH(8), .STEPS(1), .RESET_SEED(1)) dut_8 (
        .clk(clk), .rst(rst), .en(en_8), .load(1'b0), .seed(8'h00), .data_out(dout_8), .wrap(wrap_8));
    lfsr_prng #(.WIDTH(16), .STEPS(1), .RESET_SEED(1)) dut_16 (
        .clk(clk), .rst(rst), .en(en_16), .load(1'b0), .seed(16'h0000), .data_out(dout_16), .wrap(wrap_16));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] seq1 [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    logic [3:0] seq2 [15] = '{4'h4, 4'h3, 4'hD, 4'h5, 4'h7, 4'hE, 4'h8, 4'h2, 4'h9, 4'h6, 4'hA, 4'hB, 4'hF, 4'hC, 4'h1};
    logic [3:0] seq4 [4]  = '{4'h2, 4'h2, 4'h2, 4'h4};
    logic       en_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       seen8  [256];
    logic       seen16 [65536];

    initial begin
        int zeros8, dups8, wraps8, distinct8, last_wrap8;
        int zeros16, dups16, wraps16, distinct16, last_wrap16;
        rst = 1'b1; load = 1'b0; seed = 4'h0;
        en_a = 1'b0; en_b = 1'b0; en_8 = 1'b0; en_16 = 1'b0;
        #2;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_a_data", 32'(dout_a), 32'h1);
        chk("reset_a_wrap", 32'(wrap_a), 32'h0);
        chk("reset_b_data", 32'(dout_b), 32'h1);
        chk("reset_16_data", 32'(dout_16), 32'h1);

        en_a = 1'b1; en_b = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("s1_data[%0d]", i), 32'(dout_a), 32'(seq1[i]));
            chk($sformatf("s1_wrap[%0d]", i), 32'(wrap_a), 32'(i == 14));
            chk($sformatf("s2_data[%0d]", i), 32'(dout_b), 32'(seq2[i]));
            chk($sformatf("s2_wrap[%0d]", i), 32'(wrap_b), 32'(i == 14));
        end
        en_a = 1'b0; en_b = 1'b0;

        load = 1'b1; seed = 4'h0;
        tick();
        chk("load_zero_guard", 32'(dout_a), 32'h1);
        chk("load_zero_wrap", 32'(wrap_a), 32'h0);
        seed = 4'hA; en_a = 1'b1;
        tick();
        chk("load_over_en", 32'(dout_a), 32'hA);
        chk("load_over_en_wrap", 32'(wrap_a), 32'h0);
        load = 1'b0;
        tick();
        chk("after_load_step", 32'(dout_a), 32'h5);

        load = 1'b1; seed = 4'h1; en_a = 1'b0;
        tick();
        load = 1'b0;
        chk("reload_one", 32'(dout_a), 32'h1);
        for (int i = 0; i < 4; i++) begin
            en_a = en_pat[i];
            tick();
            chk($sformatf("hold_data[%0d]", i), 32'(dout_a), 32'(seq4[i]));
            chk($sformatf("hold_wrap[%0d]", i), 32'(wrap_a), 32'h0);
        end

        en_a = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("pre_reset_state", 32'(dout_a), 32'hB);
        rst = 1'b1; load = 1'b1; seed = 4'h5;
        tick();
        rst = 1'b0; load = 1'b0; en_a = 1'b0;
        chk("mid_reset_data", 32'(dout_a), 32'h1);
        chk("mid_reset_wrap", 32'(wrap_a), 32'h0);

        zeros8 = 0; dups8 = 0; wraps8 = 0; distinct8 = 0; last_wrap8 = 0;
        zeros16 = 0; dups16 = 0; wraps16 = 0; distinct16 = 0; last_wrap16 = 0;
        foreach (seen8[k]) seen8[k] = 1'b0;
        foreach (seen16[k]) seen16[k] = 1'b0;
        en_8 = 1'b1; en_16 = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            if (i == 255) en_8 = 1'b0;
            tick();
            if (i < 255) begin
                if (dout_8 == 8'h00) zeros8++;
                if (seen8[dout_8]) dups8++; else distinct8++;
                seen8[dout_8] = 1'b1;
                if (wrap_8) begin wraps8++; last_wrap8 = i; end
            end
            if (dout_16 == 16'h0000) zeros16++;
            if (seen16[dout_16]) dups16++; else distinct16++;
            seen16[dout_16] = 1'b1;
            if (wrap_16) begin wraps16++; last_wrap16 = i; end
        end
        en_16 = 1'b0;
        chk("w8_zeros", 32'(zeros8), 32'd0);
        chk("w8_dups", 32'(dups8), 32'd0);
        chk("w8_distinct", 32'(distinct8), 32'd255);
        chk("w8_wraps", 32'(wraps8), 32'd1);
        chk("w8_wrap_at", 32'(last_wrap8), 32'd254);
        chk("w8_end_state", 32'(dout_8), 32'h1);
        chk("w16_zeros", 32'(zeros16), 32'd0);
        chk("w16_dups", 32'(dups16), 32'd0);
        chk("w16_distinct", 32'(distinct16), 32'd65535);
        chk("w16_wraps", 32'(wraps16), 32'd1);
        chk("w16_wrap_at", 32'(last_wrap16), 32'd65534);
        chk("w16_end_state", 32'(dout_16), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
